// File: rtl/sar_search_ctrl_pkg.sv
// Shared definitions for the successive-approximation search controller:
// FSM state encoding, default width and a flag-validity helper.
package sar_search_ctrl_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CMP    = 2'd1,
        ST_VERIFY = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // A well-behaved comparator asserts exactly one of gt/lt/eq.
    function automatic logic flags_one_hot(input logic gt, input logic lt, input logic eq);
        logic ok;
        case ({gt, lt, eq})
            3'b100, 3'b010, 3'b001: ok = 1'b1;
            default:                ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/sar_search_ctrl.sv
// Successive-approximation search: drives a probe into an external magnitude
// comparator and resolves the unknown target MSB-first, one bit per cycle.
module sar_search_ctrl
    import sar_search_ctrl_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             cmp_gt,
    input  logic             cmp_lt,
    input  logic             cmp_eq,
    output logic [WIDTH-1:0] probe,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             found,
    output logic             err
);

    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [WIDTH-1:0] MSB_ONLY  = WIDTH'(1) << (WIDTH - 1);
    localparam logic [IDX_W-1:0] IDX_START = IDX_W'(WIDTH - 1);

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] probe_reg, probe_next;
    logic [WIDTH-1:0] result_reg, result_next;
    logic [IDX_W-1:0] idx_reg, idx_next;
    logic             busy_reg, busy_next;
    logic             found_reg, found_next;
    logic             err_reg, err_next;

    logic [WIDTH-1:0] cur_mask;
    logic [WIDTH-1:0] low_mask;
    logic [WIDTH-1:0] probe_decided;
    logic [WIDTH-1:0] probe_step;
    logic             flags_ok;

    // cur_mask selects the bit being decided; low_mask the next bit to try.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_mask
            assign cur_mask[gi] = (int'(idx_reg) == gi);
            assign low_mask[gi] = (int'(idx_reg) == gi + 1);
        end
    endgenerate

    assign flags_ok      = flags_one_hot(cmp_gt, cmp_lt, cmp_eq);
    assign probe_decided = cmp_lt ? (probe_reg & ~cur_mask) : probe_reg;
    assign probe_step    = probe_decided | low_mask;

    always_comb begin
        state_next  = state_reg;
        probe_next  = probe_reg;
        result_next = result_reg;
        idx_next    = idx_reg;
        busy_next   = busy_reg;
        found_next  = found_reg;
        err_next    = err_reg;

        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    probe_next = MSB_ONLY;
                    idx_next   = IDX_START;
                    busy_next  = 1'b1;
                    found_next = 1'b0;
                    err_next   = 1'b0;
                    state_next = ST_CMP;
                end
            end
            ST_CMP: begin
                if (!flags_ok) begin
                    err_next    = 1'b1;
                    result_next = probe_reg;
                    state_next  = ST_DONE;
                end else if (cmp_eq) begin
                    found_next  = 1'b1;
                    result_next = probe_reg;
                    state_next  = ST_DONE;
                end else if (idx_reg != '0) begin
                    probe_next = probe_step;
                    idx_next   = idx_reg - 1'b1;
                end else begin
                    probe_next = probe_decided;
                    state_next = ST_VERIFY;
                end
            end
            ST_VERIFY: begin
                result_next = probe_reg;
                found_next  = flags_ok & cmp_eq;
                err_next    = ~flags_ok;
                state_next  = ST_DONE;
            end
            ST_DONE: begin
                busy_next  = 1'b0;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= ST_IDLE;
            probe_reg  <= '0;
            result_reg <= '0;
            idx_reg    <= '0;
            busy_reg   <= 1'b0;
            found_reg  <= 1'b0;
            err_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            probe_reg  <= probe_next;
            result_reg <= result_next;
            idx_reg    <= idx_next;
            busy_reg   <= busy_next;
            found_reg  <= found_next;
            err_reg    <= err_next;
        end
    end

    assign probe  = probe_reg;
    assign busy   = busy_reg;
    assign done   = (state_reg == ST_DONE);
    assign result = result_reg;
    assign found  = found_reg;
    assign err    = err_reg;

endmodule

// File: tb/tb_sar_search_ctrl.sv
// Bench for sar_search_ctrl: an ideal 4-bit comparator closes the loop, and a
// reference model derives probe sequence, latency and outcome from the target.
module tb_sar_search_ctrl;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] target = '0;
    logic         force_both = 1'b0;
    logic         cmp_gt, cmp_lt, cmp_eq;
    logic [W-1:0] probe, result;
    logic         busy, done, found, err;

    int checks = 0;
    int fails = 0;
    int last_result = 0;

    always #5 clk = ~clk;

    // Comparator partner: target on A, probe on B; force_both corrupts the flags.
    assign cmp_gt = force_both | (target > probe);
    assign cmp_lt = force_both | (target < probe);
    assign cmp_eq = ~force_both & (target == probe);

    sar_search_ctrl #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .cmp_gt (cmp_gt),
        .cmp_lt (cmp_lt),
        .cmp_eq (cmp_eq),
        .probe  (probe),
        .busy   (busy),
        .done   (done),
        .result (result),
        .found  (found),
        .err    (err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // j-th probe: target bits above the trial bit, plus the trial bit itself.
    function automatic int probe_at(input int tgt, input int j);
        int hi = W - 1 - j;
        return ((tgt >> (hi + 1)) << (hi + 1)) | (1 << hi);
    endfunction

    // Number of compares before eq is seen (binary search stops at lowest set bit).
    function automatic int num_probes(input int tgt);
        for (int k = 0; k < W; k++)
            if (tgt[k]) return W - k;
        return W;
    endfunction

    task automatic search(input int tgt, input int inj, input bit pulse_busy, input bit do_reset);
        int np = num_probes(tgt);
        int exp_lat = (tgt == 0) ? W + 2 : np + 1;
        int exp_res = tgt;
        int exp_found = 1;
        int exp_err = 0;
        int lat = 0;
        int extra = 0;
        if (inj > 0 && inj <= np) begin
            exp_lat = inj + 1;
            exp_res = probe_at(tgt, inj - 1);
            exp_found = 0;
            exp_err = 1;
        end

        @(negedge clk);
        target = W'(tgt);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("busy_after_start", busy, 1);
        chk("found_cleared", found, 0);
        chk("err_cleared", err, 0);
        chk("result_holds", result, last_result);

        for (int n = 1; n <= 20; n++) begin
            start = 1'b0;
            if (done) begin
                lat = n;
                break;
            end
            if (n <= np && (inj == 0 || n <= inj))
                chk($sformatf("probe_t%0d_c%0d", tgt, n), probe, probe_at(tgt, n - 1));
            force_both = (n == inj);
            if (pulse_busy && n == 2) start = 1'b1;
            if (do_reset && n == 2) begin
                rst_n = 1'b0;
                #1;
                chk("rst_probe", probe, 0);
                chk("rst_busy", busy, 0);
                chk("rst_done", done, 0);
                chk("rst_result", result, 0);
                chk("rst_found", found, 0);
                chk("rst_err", err, 0);
                @(negedge clk);
                rst_n = 1'b1;
                start = 1'b0;
                force_both = 1'b0;
                last_result = 0;
                $display("search target=%0d reset mid-search", tgt);
                return;
            end
            @(posedge clk);
            #1;
        end
        force_both = 1'b0;
        start = 1'b0;

        chk($sformatf("latency_t%0d", tgt), lat, exp_lat);
        chk($sformatf("result_t%0d", tgt), result, exp_res);
        chk($sformatf("found_t%0d", tgt), found, exp_found);
        chk($sformatf("err_t%0d", tgt), err, exp_err);
        chk("busy_in_done", busy, 1);
        @(posedge clk);
        #1;
        chk("done_one_cycle", done, 0);
        chk("busy_cleared", busy, 0);
        for (int i = 0; i < 3; i++) begin
            if (done) extra++;
            @(posedge clk);
            #1;
        end
        chk("no_extra_done", extra, 0);
        chk("result_stable", result, exp_res);
        last_result = exp_res;
        $display("search target=%0d inj=%0d pulse=%0b latency=%0d result=%0d found=%0b err=%0b",
                 tgt, inj, pulse_busy, lat, result, found, err);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("reset_probe", probe, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_result", result, 0);
        chk("reset_found", found, 0);
        chk("reset_err", err, 0);
        @(negedge clk);
        rst_n = 1'b1;

        search(9, 0, 1'b0, 1'b0);
        search(0, 0, 1'b0, 1'b0);
        search(15, 0, 1'b0, 1'b0);
        search(8, 0, 1'b0, 1'b0);
        search(9, 2, 1'b0, 1'b0);
        search(9, 0, 1'b0, 1'b1);
        search(9, 0, 1'b0, 1'b0);
        search(5, 0, 1'b1, 1'b0);
        for (int r = 0; r < 12; r++)
            search(int'($urandom_range(15)), 0, 1'($urandom_range(1)), 1'b0);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
